// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_ctrl
// Description : Mode/set controller for a 24-hour BCD clock. It handles the
//               time-set and alarm-set modes and the alarm compare/timer.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
    parameter int unsigned ALARM_SECS   = 60,
    parameter int unsigned TIMEOUT_SECS = 10
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       Tick,
    input  logic       ModeKey,
    input  logic       IncKey,
    input  logic       AlmEnKey,
    input  logic [7:0] Hour,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    output logic       AdjHrkey,
    output logic       AdjMinkey,
    output logic [7:0] AlmHour,
    output logic [7:0] AlmMinute,
    output logic       AlmEn,
    output logic       Alarm,
    output logic [2:0] Mode,
    output logic       Blink
);

    localparam logic [2:0] c_ST_RUN     = 3'd0;
    localparam logic [2:0] c_ST_SET_HR  = 3'd1;
    localparam logic [2:0] c_ST_SET_MIN = 3'd2;
    localparam logic [2:0] c_ST_ALM_HR  = 3'd3;
    localparam logic [2:0] c_ST_ALM_MIN = 3'd4;

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_SECS - 1);
    localparam logic [7:0] c_ALARM_LOAD   = 8'(ALARM_SECS);

    logic       r_mode_key_q;
    logic       r_inc_key_q;
    logic       r_alm_en_key_q;
    logic [2:0] r_state;
    logic [7:0] r_timeout;
    logic [7:0] r_alarm_timer;
    logic [7:0] r_alm_hour;
    logic [7:0] r_alm_minute;
    logic       r_alm_en;
    logic       r_alarm;
    logic       r_blink;
    logic       r_adj_hr;
    logic       r_adj_min;

    logic       w_mode_edge;
    logic       w_inc_edge;
    logic       w_alm_en_edge;
    logic       w_any_edge;
    logic       w_timeout_hit;
    logic       w_state_change;
    logic       w_field_inc;
    logic       w_trigger;
    logic [2:0] w_next_state;

    function automatic logic [7:0] bcd_inc_hour(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_inc_minute(input logic [7:0] v);
        if (v[3:0] != 4'd9)
            return {v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] == 4'd5)
            return 8'h00;
        else
            return {v[7:4] + 4'd1, 4'd0};
    endfunction

    assign w_mode_edge   = ModeKey  & ~r_mode_key_q;
    assign w_inc_edge    = IncKey   & ~r_inc_key_q;
    assign w_alm_en_edge = AlmEnKey & ~r_alm_en_key_q;
    assign w_any_edge    = w_mode_edge | w_inc_edge | w_alm_en_edge;

    // A key edge on the same cycle as the last Tick clears the count instead.
    assign w_timeout_hit = (r_state != c_ST_RUN) && Tick && !w_any_edge &&
                           (r_timeout == c_TIMEOUT_LAST);

    always_comb begin
        w_next_state = r_state;
        if (w_mode_edge) begin
            case (r_state)
                c_ST_RUN:     w_next_state = c_ST_SET_HR;
                c_ST_SET_HR:  w_next_state = c_ST_SET_MIN;
                c_ST_SET_MIN: w_next_state = c_ST_ALM_HR;
                c_ST_ALM_HR:  w_next_state = c_ST_ALM_MIN;
                default:      w_next_state = c_ST_RUN;
            endcase
        end else if (w_timeout_hit || (r_state > c_ST_ALM_MIN)) begin
            w_next_state = c_ST_RUN;
        end
    end

    assign w_state_change = (w_next_state != r_state);
    assign w_field_inc    = w_inc_edge | (Tick & IncKey);
    assign w_trigger      = (r_state == c_ST_RUN) && Tick && r_alm_en &&
                            (Hour == r_alm_hour) && (Minute == r_alm_minute) &&
                            (Second == 8'h00);

    always_ff @(posedge CP) begin
        if (!nCR) begin
            r_mode_key_q   <= 1'b0;
            r_inc_key_q    <= 1'b0;
            r_alm_en_key_q <= 1'b0;
            r_state        <= c_ST_RUN;
            r_timeout      <= 8'h00;
            r_alarm_timer  <= 8'h00;
            r_alm_hour     <= 8'h00;
            r_alm_minute   <= 8'h00;
            r_alm_en       <= 1'b0;
            r_alarm        <= 1'b0;
            r_blink        <= 1'b0;
            r_adj_hr       <= 1'b0;
            r_adj_min      <= 1'b0;
        end else begin
            r_mode_key_q   <= ModeKey;
            r_inc_key_q    <= IncKey;
            r_alm_en_key_q <= AlmEnKey;
            r_state        <= w_next_state;

            r_adj_hr  <= !w_state_change && (r_state == c_ST_SET_HR)  && IncKey;
            r_adj_min <= !w_state_change && (r_state == c_ST_SET_MIN) && IncKey;

            if (w_state_change || (r_state == c_ST_RUN) || w_any_edge)
                r_timeout <= 8'h00;
            else if (Tick)
                r_timeout <= r_timeout + 8'h01;

            if (w_next_state == c_ST_RUN)
                r_blink <= 1'b0;
            else if (w_state_change)
                r_blink <= 1'b1;
            else if (Tick)
                r_blink <= ~r_blink;

            if (!w_state_change && w_field_inc) begin
                if (r_state == c_ST_ALM_HR)
                    r_alm_hour <= bcd_inc_hour(r_alm_hour);
                if (r_state == c_ST_ALM_MIN)
                    r_alm_minute <= bcd_inc_minute(r_alm_minute);
            end

            if (w_alm_en_edge)
                r_alm_en <= ~r_alm_en;

            // Any key edge stops the alarm; this also covers leaving RUN.
            if (w_any_edge) begin
                r_alarm       <= 1'b0;
                r_alarm_timer <= 8'h00;
            end else if (w_trigger) begin
                r_alarm       <= 1'b1;
                r_alarm_timer <= c_ALARM_LOAD;
            end else if (Tick && r_alarm) begin
                r_alarm_timer <= r_alarm_timer - 8'h01;
                if (r_alarm_timer <= 8'h01)
                    r_alarm <= 1'b0;
            end
        end
    end

    assign AdjHrkey  = r_adj_hr;
    assign AdjMinkey = r_adj_min;
    assign AlmHour   = r_alm_hour;
    assign AlmMinute = r_alm_minute;
    assign AlmEn     = r_alm_en;
    assign Alarm     = r_alarm;
    assign Mode      = r_state;
    assign Blink     = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_set_ctrl
// Description : Directed self-checking bench for clock_set_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

    logic       CP = 1'b0;
    logic       nCR, Tick, ModeKey, IncKey, AlmEnKey;
    logic [7:0] Hour, Minute, Second;
    logic       AdjHrkey, AdjMinkey, AlmEn, Alarm, Blink;
    logic [7:0] AlmHour, AlmMinute;
    logic [2:0] Mode;

    int total = 0;
    int bad   = 0;

    clock_set_ctrl #(.ALARM_SECS(60), .TIMEOUT_SECS(10)) dut (
        .CP(CP), .nCR(nCR), .Tick(Tick), .ModeKey(ModeKey), .IncKey(IncKey),
        .AlmEnKey(AlmEnKey), .Hour(Hour), .Minute(Minute), .Second(Second),
        .AdjHrkey(AdjHrkey), .AdjMinkey(AdjMinkey), .AlmHour(AlmHour),
        .AlmMinute(AlmMinute), .AlmEn(AlmEn), .Alarm(Alarm), .Mode(Mode),
        .Blink(Blink)
    );

    always #5 CP = ~CP;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic do_tick();
        Tick = 1'b1; step(); Tick = 1'b0;
    endtask

    task automatic press_mode();
        ModeKey = 1'b1; step(); ModeKey = 1'b0; step();
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin IncKey = 1'b1; step(); IncKey = 1'b0; step(); end
    endtask

    task automatic press_almen();
        AlmEnKey = 1'b1; step(); AlmEnKey = 1'b0; step();
    endtask

    task automatic test_reset();
        nCR = 1'b0; Tick = 1'b0; ModeKey = 1'b0; IncKey = 1'b0; AlmEnKey = 1'b0;
        Hour = 8'h00; Minute = 8'h00; Second = 8'h00;
        step(); step();
        total++; if (Mode !== 3'd0) begin bad++; $display("FAIL reset_mode actual=%0d required=0", Mode); end
        total++; if ({AdjHrkey, AdjMinkey, AlmEn, Alarm, Blink} !== 5'b0) begin bad++; $display("FAIL reset_flags actual=%b required=00000", {AdjHrkey, AdjMinkey, AlmEn, Alarm, Blink}); end
        total++; if ({AlmHour, AlmMinute} !== 16'h0000) begin bad++; $display("FAIL reset_alm_time actual=%h required=0000", {AlmHour, AlmMinute}); end
        nCR = 1'b1;
        step();
    endtask

    task automatic test_mode_cycle();
        logic [2:0] exp_mode;
        for (int i = 1; i <= 5; i++) begin
            exp_mode = 3'(i % 5);
            ModeKey = 1'b1; step();
            total++; if (Mode !== exp_mode) begin bad++; $display("FAIL mode_step%0d actual=%0d required=%0d", i, Mode, exp_mode); end
            total++; if (Blink !== (exp_mode != 3'd0)) begin bad++; $display("FAIL blink_entry%0d actual=%b required=%b", i, Blink, exp_mode != 3'd0); end
            ModeKey = 1'b0; step();
        end
    endtask

    task automatic test_time_set();
        press_mode(); press_mode();
        IncKey = 1'b1; step();
        total++; if ({AdjMinkey, AdjHrkey} !== 2'b10) begin bad++; $display("FAIL adjmin_rise actual=%b required=10", {AdjMinkey, AdjHrkey}); end
        for (int i = 0; i < 3; i++) begin
            do_tick();
            total++; if ({AdjMinkey, AdjHrkey} !== 2'b10) begin bad++; $display("FAIL adjmin_hold%0d actual=%b required=10", i, {AdjMinkey, AdjHrkey}); end
        end
        total++; if (Blink !== 1'b0) begin bad++; $display("FAIL blink_toggle actual=%b required=0", Blink); end
        IncKey = 1'b0; step();
        total++; if (AdjMinkey !== 1'b0) begin bad++; $display("FAIL adjmin_fall actual=%b required=0", AdjMinkey); end
        press_mode();
    endtask

    task automatic test_alarm_wrap();
        logic [7:0] exp_hr [4];
        exp_hr[0] = 8'h23; exp_hr[1] = 8'h00; exp_hr[2] = 8'h01; exp_hr[3] = 8'h02;
        press_inc(22);
        total++; if (AlmHour !== 8'h22) begin bad++; $display("FAIL almhr_22 actual=%h required=22", AlmHour); end
        IncKey = 1'b1; step();
        total++; if (AlmHour !== exp_hr[0]) begin bad++; $display("FAIL almhr_edge actual=%h required=%h", AlmHour, exp_hr[0]); end
        for (int i = 1; i < 4; i++) begin
            do_tick();
            total++; if (AlmHour !== exp_hr[i]) begin bad++; $display("FAIL almhr_repeat%0d actual=%h required=%h", i, AlmHour, exp_hr[i]); end
        end
        IncKey = 1'b0; step();
        press_mode();
        press_inc(59);
        total++; if (AlmMinute !== 8'h59) begin bad++; $display("FAIL almmin_59 actual=%h required=59", AlmMinute); end
        press_inc(1);
        total++; if ({AlmHour, AlmMinute} !== 16'h0200) begin bad++; $display("FAIL almmin_wrap actual=%h required=0200", {AlmHour, AlmMinute}); end
        press_mode();
        total++; if (Mode !== 3'd0) begin bad++; $display("FAIL back_to_run actual=%0d required=0", Mode); end
    endtask

    task automatic test_timeout();
        press_mode();
        repeat (9) do_tick();
        total++; if (Mode !== 3'd1) begin bad++; $display("FAIL timeout_early actual=%0d required=1", Mode); end
        do_tick();
        total++; if ({Mode, Blink} !== 4'b0000) begin bad++; $display("FAIL timeout_hit actual=%b required=0000", {Mode, Blink}); end
        press_mode();
        repeat (8) do_tick();
        IncKey = 1'b1; Tick = 1'b1; step(); Tick = 1'b0;
        total++; if ({Mode, AdjHrkey} !== 4'b0011) begin bad++; $display("FAIL timeout_restart actual=%b required=0011", {Mode, AdjHrkey}); end
        repeat (9) do_tick();
        total++; if ({Mode, AdjHrkey} !== 4'b0011) begin bad++; $display("FAIL timeout_recount actual=%b required=0011", {Mode, AdjHrkey}); end
        do_tick();
        total++; if ({Mode, AdjHrkey} !== 4'b0000) begin bad++; $display("FAIL timeout_adjhr actual=%b required=0000", {Mode, AdjHrkey}); end
        IncKey = 1'b0; step();
    endtask

    task automatic test_back_to_back();
        press_mode();
        repeat (9) do_tick();
        ModeKey = 1'b1; Tick = 1'b1; step(); Tick = 1'b0; ModeKey = 1'b0;
        total++; if (Mode !== 3'd2) begin bad++; $display("FAIL mode_beats_timeout actual=%0d required=2", Mode); end
        step();
        press_mode(); press_mode(); press_mode();
        total++; if (Mode !== 3'd0) begin bad++; $display("FAIL b2b_run actual=%0d required=0", Mode); end
    endtask

    task automatic test_alarm_fire();
        press_mode(); press_mode(); press_mode();
        press_inc(5);
        press_mode();
        press_inc(30);
        press_mode();
        total++; if ({AlmHour, AlmMinute} !== 16'h0730) begin bad++; $display("FAIL alm_set actual=%h required=0730", {AlmHour, AlmMinute}); end
        press_almen();
        total++; if (AlmEn !== 1'b1) begin bad++; $display("FAIL almen_on actual=%b required=1", AlmEn); end
        Hour = 8'h07; Minute = 8'h30; Second = 8'h00;
        do_tick();
        total++; if (Alarm !== 1'b1) begin bad++; $display("FAIL alarm_fire actual=%b required=1", Alarm); end
        Second = 8'h01;
        repeat (59) do_tick();
        total++; if (Alarm !== 1'b1) begin bad++; $display("FAIL alarm_hold59 actual=%b required=1", Alarm); end
        do_tick();
        total++; if (Alarm !== 1'b0) begin bad++; $display("FAIL alarm_expire actual=%b required=0", Alarm); end
    endtask

    task automatic test_alarm_stop();
        Second = 8'h00; do_tick(); Second = 8'h01;
        IncKey = 1'b1; step();
        total++; if (Alarm !== 1'b0) begin bad++; $display("FAIL alarm_snooze actual=%b required=0", Alarm); end
        IncKey = 1'b0; step();
        Second = 8'h00; do_tick(); Second = 8'h01;
        repeat (30) do_tick();
        Second = 8'h00; do_tick(); Second = 8'h01;
        repeat (59) do_tick();
        total++; if (Alarm !== 1'b1) begin bad++; $display("FAIL alarm_reload actual=%b required=1", Alarm); end
        do_tick();
        total++; if (Alarm !== 1'b0) begin bad++; $display("FAIL alarm_reload_end actual=%b required=0", Alarm); end
        Second = 8'h00; do_tick(); Second = 8'h01;
        AlmEnKey = 1'b1; step();
        total++; if ({AlmEn, Alarm} !== 2'b00) begin bad++; $display("FAIL almen_clear actual=%b required=00", {AlmEn, Alarm}); end
        AlmEnKey = 1'b0; step();
        Second = 8'h00; do_tick(); Second = 8'h01;
        total++; if (Alarm !== 1'b0) begin bad++; $display("FAIL alarm_gated actual=%b required=0", Alarm); end
        press_almen();
        Minute = 8'h31; Second = 8'h00; do_tick(); Second = 8'h01;
        total++; if (Alarm !== 1'b0) begin bad++; $display("FAIL alarm_nomatch actual=%b required=0", Alarm); end
        Minute = 8'h30; Second = 8'h00; do_tick(); Second = 8'h01;
        ModeKey = 1'b1; step();
        total++; if ({Mode, Alarm} !== 4'b0010) begin bad++; $display("FAIL alarm_leave_run actual=%b required=0010", {Mode, Alarm}); end
        ModeKey = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        nCR = 1'b0; step();
        total++; if ({Mode, AlmEn, AlmHour, AlmMinute} !== 20'h0) begin bad++; $display("FAIL reset_mid actual=%h required=00000", {Mode, AlmEn, AlmHour, AlmMinute}); end
        nCR = 1'b1; step();
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_time_set();
        test_alarm_wrap();
        test_timeout();
        test_back_to_back();
        test_alarm_fire();
        test_alarm_stop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
